// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_pkg
// Description : Shared definitions for the M:SS.t stopwatch controller.
//               Holds the controller state encoding, the per-digit moduli,
//               the saturation value 9:59.9 and small digit helpers.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        PAUSE = 3'd2,
        LAP   = 3'd3,
        OVF   = 3'd4
    } sw_state_t;

    localparam int NUM_DIGITS   = 4;
    localparam int MOD_TENTHS   = 10;  // d0
    localparam int MOD_SEC_ONES = 10;  // d1
    localparam int MOD_SEC_TENS = 6;   // d2
    localparam int MOD_MINUTES  = 10;  // d3

    // Packed as {d3, d2, d1, d0}, one BCD nibble per digit: 9:59.9
    localparam logic [15:0] MAX_VAL = 16'h9599;

    function automatic int digit_mod(input int idx);
        case (idx)
            0:       return MOD_TENTHS;
            1:       return MOD_SEC_ONES;
            2:       return MOD_SEC_TENS;
            default: return MOD_MINUTES;
        endcase
    endfunction

    function automatic logic [3:0] digit_sel(input logic [15:0] v, input logic [1:0] idx);
        return v[{idx, 2'b00} +: 4];
    endfunction

    function automatic logic is_max(input logic [15:0] v);
        return v == MAX_VAL;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_cnt.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_cnt
// Description : One BCD digit of the stopwatch counter, counting 0..MOD-1.
// Ports       : clk   - system clock
//               rst_n - asynchronous active-low reset (digit -> 0)
//               inc   - advance by one this edge, wrapping MOD-1 -> 0
//               clr   - synchronous clear to 0 (wins over inc)
//               val   - current digit value
//               carry - terminal count: digit currently holds MOD-1, so an
//                       inc on this edge rolls over into the next digit
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_cnt #(
    parameter int MOD = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] val,
    output logic       carry
);

    localparam logic [3:0] LAST = 4'(MOD - 1);

    logic [3:0] val_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q <= 4'd0;
        end else if (clr) begin
            val_q <= 4'd0;
        end else if (inc) begin
            val_q <= (val_q == LAST) ? 4'd0 : val_q + 4'd1;
        end
    end

    assign val   = val_q;
    assign carry = (val_q == LAST);

endmodule
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_ctrl
// Description : M:SS.t stopwatch. Four chained BCD digits count 0.1 s ticks
//               while running, a lap register freezes the display in LAP,
//               and a 4-digit multiplexed display scan drives an_n/bcd/dp_n.
// Ports       : clk, rst_n       - clock, asynchronous active-low reset
//               tick             - 0.1 s count-enable pulse
//               refresh_tick     - display scan advance pulse
//               btn_ss/clr/lap   - one-cycle start-stop / clear / lap pulses
//               an_n             - active-low one-hot anode select
//               bcd              - BCD value of the selected digit
//               dp_n             - active-low decimal point
//               state            - controller state encoding
//               ovf              - high while saturated at 9:59.9
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl
    import stopwatch_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       refresh_tick,
    input  logic       btn_ss,
    input  logic       btn_clr,
    input  logic       btn_lap,
    output logic [3:0] an_n,
    output logic [3:0] bcd,
    output logic       dp_n,
    output logic [2:0] state,
    output logic       ovf
);

    sw_state_t   state_q, state_d;
    logic [15:0] lap_q;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  an_n_q, bcd_q;
    logic        dp_n_q, ovf_q;

    logic        w_clr, w_ss, w_lap;
    logic        w_counting, w_cnt_en, w_at_max, w_wrap, w_clr_cnt;
    logic [3:0]  w_inc, w_tc;
    logic [3:0]  w_val [NUM_DIGITS];
    logic [15:0] w_live, w_disp;

    // Fixed priority clr > ss > lap: the winner is chosen before the state
    // decides whether it means anything, so a losing pulse is always lost.
    assign w_clr = btn_clr;
    assign w_ss  = btn_ss & ~btn_clr;
    assign w_lap = btn_lap & ~btn_ss & ~btn_clr;

    assign w_counting = (state_q == RUN) || (state_q == LAP);
    assign w_cnt_en   = tick & w_counting;
    assign w_live     = {w_val[3], w_val[2], w_val[1], w_val[0]};
    assign w_at_max   = is_max(w_live);

    // Ripple the tick through the terminal-count flags. The digits are
    // frozen at 9:59.9; the fully propagated carry marks the tick that
    // would have rolled the display over, which is what sends us to OVF.
    always_comb begin
        logic v_chain;
        v_chain = w_cnt_en;
        w_inc   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_inc[i] = v_chain & ~w_at_max;
            v_chain  = v_chain & w_tc[i];
        end
        w_wrap = v_chain;
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_digit_cnt #(
            .MOD(digit_mod(g))
        ) u_digit (
            .clk  (clk),
            .rst_n(rst_n),
            .inc  (w_inc[g]),
            .clr  (w_clr_cnt),
            .val  (w_val[g]),
            .carry(w_tc[g])
        );
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (w_ss) state_d = RUN;
            RUN:     if (w_ss) state_d = PAUSE; else if (w_lap) state_d = LAP;
            PAUSE:   if (w_clr) state_d = IDLE; else if (w_ss) state_d = RUN;
            LAP:     if (w_ss) state_d = PAUSE; else if (w_lap) state_d = RUN;
            OVF:     if (w_clr) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A rollover tick overrides any button in the same cycle.
        if (w_wrap) state_d = OVF;
    end

    // Digits are zeroed on the edge that lands in IDLE and held there.
    assign w_clr_cnt = (state_d == IDLE);

    assign w_disp = (state_q == LAP) ? lap_q : w_live;
    assign idx_d  = idx_q + {1'b0, refresh_tick};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lap_q   <= 16'd0;
            idx_q   <= 2'd0;
            an_n_q  <= 4'b1110;
            bcd_q   <= 4'd0;
            dp_n_q  <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ovf_q   <= (state_d == OVF);
            // Capture the value on screen at the moment LAP is entered.
            if ((state_d == LAP) && (state_q != LAP)) begin
                lap_q <= w_live;
            end
            idx_q  <= idx_d;
            an_n_q <= ~(4'b0001 << idx_d);
            bcd_q  <= digit_sel(w_disp, idx_d);
            // Points after seconds-units (SS.t) and after minutes (M:SS).
            dp_n_q <= ~idx_d[0];
        end
    end

    assign an_n  = an_n_q;
    assign bcd   = bcd_q;
    assign dp_n  = dp_n_q;
    assign state = state_q;
    assign ovf   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch_ctrl
// Description : Self-checking bench for stopwatch_ctrl. A reference model
//               keeps the elapsed time as an integer count of tenths and
//               derives digits arithmetically; every cycle the DUT outputs
//               are compared against it, alongside a transition table and
//               directed multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       tick = 1'b0, refresh_tick = 1'b0;
    logic       btn_ss = 1'b0, btn_clr = 1'b0, btn_lap = 1'b0;
    logic [3:0] an_n, bcd;
    logic       dp_n, ovf;
    logic [2:0] state;

    stopwatch_ctrl u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .refresh_tick(refresh_tick),
        .btn_ss      (btn_ss),
        .btn_clr     (btn_clr),
        .btn_lap     (btn_lap),
        .an_n        (an_n),
        .bcd         (bcd),
        .dp_n        (dp_n),
        .state       (state),
        .ovf         (ovf)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: states 0 IDLE, 1 RUN, 2 PAUSE, 3 LAP, 4 OVF; time in tenths.
    int m_state, m_cnt, m_lap, m_idx, m_bcd;

    typedef struct {
        bit tk;
        bit ss;
        bit clr;
        bit lap;
        int exp_state;
    } vec_t;

    vec_t vt[15];

    function automatic int digit_of(input int v, input int i);
        case (i)
            0:       return v % 10;
            1:       return (v / 10) % 10;
            2:       return (v / 100) % 6;
            default: return v / 600;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_step(input bit t, input bit r, input bit s,
                                       input bit c, input bit l);
        int  shown;
        int  ns;
        bit  p_ss, p_lap;
        shown = (m_state == 3) ? m_lap : m_cnt;
        ns    = m_state;
        p_ss  = s && !c;
        p_lap = l && !s && !c;
        case (m_state)
            0: if (p_ss) ns = 1;
            1: if (p_ss) ns = 2; else if (p_lap) ns = 3;
            2: if (c) ns = 0; else if (p_ss) ns = 1;
            3: if (p_ss) ns = 2; else if (p_lap) ns = 1;
            default: if (c) ns = 0;
        endcase
        if (t && (m_state == 1 || m_state == 3)) begin
            if (m_cnt == 5999) ns = 4;
            else               m_cnt = m_cnt + 1;
        end
        if (ns == 3 && m_state != 3) m_lap = shown;
        if (ns == 0) m_cnt = 0;
        if (r) m_idx = (m_idx + 1) % 4;
        m_bcd   = digit_of(shown, m_idx);
        m_state = ns;
    endfunction

    task automatic check_outputs();
        chk("state", int'(state), m_state);
        chk("ovf", int'(ovf), (m_state == 4) ? 1 : 0);
        chk("an_n", int'(an_n), 15 & ~(1 << m_idx));
        chk("bcd", int'(bcd), m_bcd);
        chk("dp_n", int'(dp_n), (m_idx % 2 == 0) ? 1 : 0);
    endtask

    task automatic cycle(input bit t, input bit r, input bit s, input bit c, input bit l);
        tick = t; refresh_tick = r; btn_ss = s; btn_clr = c; btn_lap = l;
        @(posedge clk);
        model_step(t, r, s, c, l);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        tick = 0; refresh_tick = 0; btn_ss = 0; btn_clr = 0; btn_lap = 0;
        rst_n = 1'b0;
        #2;
        chk("rst_an_n", int'(an_n), 4'b1110);
        chk("rst_bcd", int'(bcd), 0);
        chk("rst_dp_n", int'(dp_n), 1);
        chk("rst_state", int'(state), 0);
        chk("rst_ovf", int'(ovf), 0);
        m_state = 0; m_cnt = 0; m_lap = 0; m_idx = 0; m_bcd = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        model_step(0, 0, 0, 0, 0);
        #1;
        check_outputs();
    endtask

    task automatic ticks(input int n);
        repeat (n) cycle(1, 0, 0, 0, 0);
    endtask

    // Scan all four digits and rebuild the shown time in tenths.
    task automatic scan_value(output int v);
        int d[4];
        repeat (4) begin
            cycle(0, 1, 0, 0, 0);
            d[m_idx] = int'(bcd);
        end
        v = d[3] * 600 + d[2] * 100 + d[1] * 10 + d[0];
    endtask

    task automatic rand_cycle();
        bit t, r, s, c, l;
        t = ($urandom % 2) == 0;
        r = ($urandom % 3) == 0;
        s = ($urandom % 12) == 0;
        c = ($urandom % 16) == 0;
        l = ($urandom % 10) == 0;
        cycle(t, r, s, c, l);
    endtask

    initial begin
        int v;
        logic [3:0] exp_an [4];
        int exp_bcd [4];
        int exp_dp [4];

        vt[0]  = '{0, 0, 0, 1, 0};
        vt[1]  = '{0, 0, 1, 0, 0};
        vt[2]  = '{0, 1, 0, 1, 1};
        vt[3]  = '{0, 0, 1, 0, 1};
        vt[4]  = '{1, 0, 0, 1, 3};
        vt[5]  = '{1, 0, 0, 0, 3};
        vt[6]  = '{0, 1, 0, 1, 2};
        vt[7]  = '{0, 0, 0, 1, 2};
        vt[8]  = '{1, 0, 0, 0, 2};
        vt[9]  = '{0, 1, 0, 0, 1};
        vt[10] = '{0, 0, 0, 1, 3};
        vt[11] = '{0, 0, 0, 1, 1};
        vt[12] = '{1, 1, 0, 0, 2};
        vt[13] = '{0, 0, 1, 0, 0};
        vt[14] = '{0, 1, 0, 0, 1};

        exp_an[0] = 4'b1101; exp_bcd[0] = 5; exp_dp[0] = 0;
        exp_an[1] = 4'b1011; exp_bcd[1] = 4; exp_dp[1] = 1;
        exp_an[2] = 4'b0111; exp_bcd[2] = 3; exp_dp[2] = 0;
        exp_an[3] = 4'b1110; exp_bcd[3] = 6; exp_dp[3] = 1;

        #1;
        do_reset();

        // Transition table
        for (int i = 0; i < 15; i++) begin
            cycle(vt[i].tk, 0, vt[i].ss, vt[i].clr, vt[i].lap);
            chk($sformatf("tbl%0d_state", i), int'(state), vt[i].exp_state);
        end

        // Start and count 123 ticks -> 0:12.3
        do_reset();
        cycle(0, 0, 1, 0, 0);
        ticks(123);
        scan_value(v);
        chk("run123_value", v, 123);
        chk("run123_state", int'(state), 1);

        // Lap freezes the display at 0:05.0, release shows 0:07.0
        do_reset();
        cycle(0, 0, 1, 0, 0);
        ticks(50);
        cycle(0, 0, 0, 0, 1);
        ticks(20);
        scan_value(v);
        chk("lap_frozen", v, 50);
        chk("lap_state", int'(state), 3);
        cycle(0, 0, 0, 0, 1);
        scan_value(v);
        chk("lap_release", v, 70);

        // Stop coincident with tick is counted; paused ticks are not
        do_reset();
        cycle(0, 0, 1, 0, 0);
        ticks(42);
        cycle(1, 0, 1, 0, 0);
        chk("stop_state", int'(state), 2);
        scan_value(v);
        chk("stop_tick_counted", v, 43);
        ticks(5);
        scan_value(v);
        chk("pause_hold", v, 43);
        cycle(0, 0, 0, 1, 0);
        chk("clr_state", int'(state), 0);
        scan_value(v);
        chk("clr_value", v, 0);

        // All three buttons in PAUSE: clear wins
        do_reset();
        cycle(0, 0, 1, 0, 0);
        ticks(17);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 1, 1, 1);
        chk("all_btn_state", int'(state), 0);
        scan_value(v);
        chk("all_btn_value", v, 0);

        // Saturation at 9:59.9
        do_reset();
        cycle(0, 0, 1, 0, 0);
        ticks(5998);
        scan_value(v);
        chk("pre_max_value", v, 5998);
        ticks(2);
        scan_value(v);
        chk("max_value", v, 5999);
        chk("ovf_state", int'(state), 4);
        chk("ovf_flag", int'(ovf), 1);
        cycle(0, 0, 1, 0, 0);
        chk("ovf_ss_ignored", int'(state), 4);
        scan_value(v);
        chk("ovf_hold", v, 5999);
        cycle(0, 0, 0, 1, 0);
        chk("ovf_clr_state", int'(state), 0);
        chk("ovf_clr_flag", int'(ovf), 0);

        // Scan sequence at 3:45.6, then reset mid-scan
        do_reset();
        cycle(0, 0, 1, 0, 0);
        ticks(2256);
        cycle(0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, 0, 0, 0);
            chk($sformatf("scan%0d_an_n", i), int'(an_n), int'(exp_an[i]));
            chk($sformatf("scan%0d_bcd", i), int'(bcd), exp_bcd[i]);
            chk($sformatf("scan%0d_dp_n", i), int'(dp_n), exp_dp[i]);
        end
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        do_reset();

        // Random traffic from zero
        do_reset();
        repeat (3000) rand_cycle();

        // Random traffic around the saturation point
        do_reset();
        cycle(0, 0, 1, 0, 0);
        ticks(5990);
        repeat (300) rand_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter: none; the digit moduli are fixed as 10, 10, 6 and 10, and the display format is M:SS.t.
REQ-002 clk  in  1  single system clock; all state SHALL change on its rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 tick  in  1  one-cycle count-enable pulse from clk_divider, once per 0.1 s.
REQ-005 refresh_tick  in  1  one-cycle display-scan pulse from clk_divider.
REQ-006 btn_ss  in  1  debounced one-cycle start/stop pulse.
REQ-007 btn_clr  in  1  debounced one-cycle clear pulse.
REQ-008 btn_lap  in  1  debounced one-cycle lap pulse.
REQ-009 an_n  out  4  active-low one-hot digit anode select.
REQ-010 bcd  out  4  BCD value of the digit currently selected by an_n.
REQ-011 dp_n  out  1  active-low decimal point for the selected digit.
REQ-012 state  out  3  current controller state encoding.
REQ-013 ovf  out  1  high while in state OVF.

Function
REQ-014 Counter SHALL be four BCD digits: d0 tenths (mod 10), d1 seconds units (mod 10), d2 seconds tens (mod 6), d3 minutes (mod 10).
REQ-015 When tick=1 in RUN or LAP, the counter SHALL increment by one in that same edge; each digit wraps to 0 and carries into the next digit.
REQ-016 States SHALL be IDLE, RUN, PAUSE, LAP and OVF.
REQ-017 Transitions SHALL be:
- IDLE --btn_ss--> RUN
- RUN --btn_ss--> PAUSE
- RUN --btn_lap--> LAP
- LAP --btn_lap--> RUN
- LAP --btn_ss--> PAUSE
- PAUSE --btn_ss--> RUN
- PAUSE --btn_clr--> IDLE
- OVF --btn_clr--> IDLE
REQ-018 btn_clr SHALL be ignored in RUN and LAP, and btn_lap SHALL be ignored in IDLE, PAUSE and OVF.
REQ-019 Simultaneous buttons SHALL be prioritised btn_clr > btn_ss > btn_lap; lower-priority pulses in the same cycle are dropped.
REQ-020 Entering IDLE SHALL zero all digits in the same edge.
REQ-021 A tick coincident with btn_ss in RUN or LAP SHALL be counted; a tick coincident with btn_ss in PAUSE or IDLE SHALL NOT be counted.
REQ-022 A tick at value 9:59.9 in RUN or LAP SHALL leave the counter at 9:59.9 and enter OVF; the counter holds in OVF.
REQ-023 On entry to LAP, the displayed value SHALL be latched into a lap register; while in LAP the display shows the lap register, otherwise it shows the live counter.
REQ-024 A 2-bit scan index SHALL advance 0→1→2→3→0 on each refresh_tick, in any state.
REQ-025 an_n, bcd and dp_n SHALL be registered and SHALL reflect the new scan index one cycle after refresh_tick; index i drives an_n bit i low.
REQ-026 dp_n SHALL be 0 for index 1 (SS.t point) and index 3 (M:SS separator), and 1 otherwise.
REQ-027 tick and refresh_tick SHALL be handled independently; coincident pulses both take effect.

Reset
REQ-028 When rst_n=0, the block SHALL immediately apply: state=IDLE, all digits=0, lap register=0, scan index=0, an_n=4'b1110, bcd=0, dp_n=1, ovf=0.
REQ-029 Reset asserted mid-count SHALL discard all counter and lap contents; after release, operation resumes from IDLE on the first clk edge.

Structure
REQ-030 Package stopwatch_pkg SHALL hold the state encoding (IDLE=0, RUN=1, PAUSE=2, LAP=3, OVF=4), the digit moduli and the max-value constant 9:59.9.
REQ-031 Sub-module bcd_digit_cnt SHALL implement one digit (parameter MOD; inputs inc and clr; outputs val and carry) and SHALL be instantiated four times.
REQ-032 FSM, lap register and scan logic SHALL reside in stopwatch_ctrl.

Verification
REQ-033 Reset, btn_ss, 123 ticks → live value 0:12.3; state=RUN.
REQ-034 In RUN at 0:05.0, btn_lap, 20 ticks → display shows 0:05.0; btn_lap → display shows 0:07.0.
REQ-035 In RUN, btn_ss and tick in the same cycle → value +1, state=PAUSE; 5 further ticks → no change; btn_clr → 0:00.0, IDLE.
REQ-036 Counter preloaded by ticks to 9:59.8, two ticks → 9:59.9, state=OVF, ovf=1; btn_ss → no change; btn_clr → IDLE, ovf=0.
REQ-037 btn_clr, btn_ss and btn_lap all pulsed in the same cycle in PAUSE → IDLE, counter zero.
REQ-038 Value 3:45.6, four refresh_ticks → (an_n, bcd, dp_n) sequence (1101, 5, 0), (1011, 4, 1), (0111, 3, 0), (1110, 6, 1); rst_n pulsed mid-sequence → an_n=1110, bcd=0 immediately.
